// File: rtl/ifu_prefetch_if.sv
// ifu_prefetch_if: bundles the redirect input, the instruction-memory request/response
// channel and the decode valid/ready channel of the instruction prefetch stage.
// The master modport is the prefetch stage. The slave modport is its environment:
// the execute redirect source, the instruction memory and the decoder.
interface ifu_prefetch_if;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_addr;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] instr_pc;

   modport master (
      input  redirect, redirect_pc, imem_req_ready, imem_rvalid, imem_rdata, instr_ready,
      output imem_req_valid, imem_addr, instr_valid, instr, instr_pc
   );

   modport slave (
      output redirect, redirect_pc, imem_req_ready, imem_rvalid, imem_rdata, instr_ready,
      input  imem_req_valid, imem_addr, instr_valid, instr, instr_pc
   );
endinterface

// File: rtl/ifu_prefetch.sv
// ifu_prefetch: instruction prefetch stage in front of the decoder.
// It issues sequential word-aligned fetches to a variable-latency, in-order
// instruction memory. The PC of every accepted request is queued so that each
// response can be paired with its PC. Returned words are buffered in a DEPTH-entry
// FIFO and handed to decode over valid/ready.
// Request credit is count + outstanding < DEPTH, so every response is guaranteed a
// FIFO slot. A redirect empties the FIFO, restarts fetch at the target and arms a
// drop counter that discards the responses still due from the wrong path.
// Optional build macro IFU_BYPASS_EN: a response that finds the FIFO empty is
// presented to decode combinationally in the same cycle. If decode takes it that
// cycle, it is never written into the FIFO.
module ifu_prefetch #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
   input logic           clk,
   input logic           reset,
   ifu_prefetch_if.master bus
);

   localparam int            AW      = $clog2(DEPTH);
   localparam int            CW      = AW + 1;
   localparam logic [CW:0]   DEPTH_S = (CW+1)'(DEPTH);

   function automatic logic [31:0] word_align(input logic [31:0] a);
      return a & 32'hFFFF_FFFC;
   endfunction

   // Fetch (request) stage state
   logic [31:0]   fetch_pc_p0;
   logic [CW-1:0] outstanding_p0;
   logic [31:0]   pcq_p0 [DEPTH];
   logic [AW-1:0] pcq_wr_p0;
   logic [AW-1:0] pcq_rd_p0;

   // Response / buffer stage state
   logic [CW-1:0] drop_p1;
   logic [CW-1:0] count_p1;
   logic [31:0]   fifo_word_p1 [DEPTH];
   logic [31:0]   fifo_pc_p1 [DEPTH];
   logic [AW-1:0] fifo_wr_p1;
   logic [AW-1:0] fifo_rd_p1;

   logic          credit;
   logic          req_vld_p0;
   logic          accept;
   logic [31:0]   rsp_pc;
   logic          rsp_live;
   logic          vld_p1;
   logic          byp_vld;
   logic          byp_take;
   logic          push;
   logic          pop;

   // Issue a request only while every in-flight response still has a FIFO slot.
   // Gating with the reset pin keeps the request low for the whole reset.
   assign credit     = ({1'b0, count_p1} + {1'b0, outstanding_p0}) < DEPTH_S;
   assign req_vld_p0 = reset && credit && !bus.redirect;
   assign accept     = req_vld_p0 && bus.imem_req_ready;

   assign bus.imem_req_valid = req_vld_p0;
   assign bus.imem_addr      = fetch_pc_p0;

   // The oldest queued PC belongs to the response currently on the bus.
   assign rsp_pc   = pcq_p0[pcq_rd_p0];
   assign rsp_live = bus.imem_rvalid && (drop_p1 == '0) && !bus.redirect;
   assign vld_p1   = (count_p1 != '0);

`ifdef IFU_BYPASS_EN
   assign byp_vld  = rsp_live && !vld_p1;
   assign byp_take = byp_vld && bus.instr_ready;
`else
   assign byp_vld  = 1'b0;
   assign byp_take = 1'b0;
`endif

   // A redirect pop is seen by decode, but the FIFO is cleared anyway.
   assign push = rsp_live && !byp_take;
   assign pop  = vld_p1 && bus.instr_ready && !bus.redirect;

   // Decode sees the registered FIFO head, or the bypassed response when the FIFO is empty.
   always_comb begin
      bus.instr_valid = vld_p1 || byp_vld;
      bus.instr       = '0;
      bus.instr_pc    = '0;
      if (vld_p1) begin
         bus.instr    = fifo_word_p1[fifo_rd_p1];
         bus.instr_pc = fifo_pc_p1[fifo_rd_p1];
      end else if (byp_vld) begin
         bus.instr    = bus.imem_rdata;
         bus.instr_pc = rsp_pc;
      end
   end

   // Fetch PC: restart at the aligned redirect target, otherwise advance on each accept.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_pc_p0 <= RESET_PC;
      end else if (bus.redirect) begin
         fetch_pc_p0 <= word_align(bus.redirect_pc);
      end else if (accept) begin
         fetch_pc_p0 <= fetch_pc_p0 + 32'd4;
      end
   end

   // Outstanding requests: +1 per accept, -1 per response (wrong-path ones included).
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         outstanding_p0 <= '0;
      end else begin
         case ({accept, bus.imem_rvalid})
            2'b10:   outstanding_p0 <= outstanding_p0 + CW'(1);
            2'b01:   outstanding_p0 <= outstanding_p0 - CW'(1);
            default: outstanding_p0 <= outstanding_p0;
         endcase
      end
   end

   // Drop counter: on redirect, every response still due is wrong-path; the one arriving now is already discarded.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         drop_p1 <= '0;
      end else if (bus.redirect) begin
         drop_p1 <= outstanding_p0 - CW'(bus.imem_rvalid);
      end else if (bus.imem_rvalid && (drop_p1 != '0)) begin
         drop_p1 <= drop_p1 - CW'(1);
      end
   end

   // PC queue pointers: written on accept, read on every response so pairing stays in order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pcq_wr_p0 <= '0;
         pcq_rd_p0 <= '0;
      end else begin
         if (accept) begin
            pcq_wr_p0 <= pcq_wr_p0 + AW'(1);
         end
         if (bus.imem_rvalid) begin
            pcq_rd_p0 <= pcq_rd_p0 + AW'(1);
         end
      end
   end

   // PC queue storage: records the address of each accepted request.
   always_ff @(posedge clk) begin
      if (accept) begin
         pcq_p0[pcq_wr_p0] <= fetch_pc_p0;
      end
   end

   // FIFO control: a redirect empties it; otherwise push/pop move the pointers and the occupancy.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_p1   <= '0;
         fifo_wr_p1 <= '0;
         fifo_rd_p1 <= '0;
      end else if (bus.redirect) begin
         count_p1   <= '0;
         fifo_wr_p1 <= '0;
         fifo_rd_p1 <= '0;
      end else begin
         if (push) begin
            fifo_wr_p1 <= fifo_wr_p1 + AW'(1);
         end
         if (pop) begin
            fifo_rd_p1 <= fifo_rd_p1 + AW'(1);
         end
         case ({push, pop})
            2'b10:   count_p1 <= count_p1 + CW'(1);
            2'b01:   count_p1 <= count_p1 - CW'(1);
            default: count_p1 <= count_p1;
         endcase
      end
   end

   // FIFO storage: the word and its PC are captured together.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_word_p1[fifo_wr_p1] <= bus.imem_rdata;
         fifo_pc_p1[fifo_wr_p1]   <= rsp_pc;
      end
   end

   // A response with nothing in flight means the memory side broke the one-response-per-request contract.
   a_rvalid_without_request: assert property (@(posedge clk) disable iff (!reset)
      !(bus.imem_rvalid && (outstanding_p0 == '0)));

endmodule

// File: tb/tb_ifu_prefetch.sv
// tb_ifu_prefetch: directed and randomized bench for ifu_prefetch.
// An in-order memory with programmable latency answers the DUT's requests.
// A queue-based reference model tags each request with a redirect epoch and
// predicts every output of the DUT in every cycle.
module tb_ifu_prefetch;
   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_3000;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   ifu_prefetch_if bus();

   ifu_prefetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int lat_min = 1;
   int lat_max = 1;
   int acc_cnt = 0;
   int valid_cnt = 0;
   logic [31:0] acc_addr[$];
   logic [31:0] seen_pc[$];

   typedef struct {logic [31:0] addr; int due;} mreq_t;
   typedef struct {logic [31:0] pc; int ep;} infl_t;
   typedef struct {logic [31:0] w; logic [31:0] pc;} ent_t;

   mreq_t mem_q[$];
   infl_t infl[$];
   ent_t  mq[$];
   logic [31:0] m_pc = RESET_PC;
   int ep = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   // One clock cycle: present the memory response, check at negedge, advance model at posedge.
   task automatic cycle();
      logic rv, r, exp_req, exp_iv, keep, byp, mq_was_empty;
      logic [31:0] exp_i, exp_pc;
      infl_t h;
      h = '{pc: 32'h0, ep: 0};
      rv = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
      bus.imem_rvalid = rv;
      if (rv) bus.imem_rdata = mem_word(mem_q[0].addr);
      else    bus.imem_rdata = $urandom();
      @(negedge clk);
      r = bus.redirect;
      exp_req = ((mq.size() + infl.size()) < DEPTH) && !r;
      exp_iv = (mq.size() > 0);
      exp_i  = 32'h0;
      exp_pc = 32'h0;
      if (exp_iv) begin
         exp_i  = mq[0].w;
         exp_pc = mq[0].pc;
      end
`ifdef IFU_BYPASS_EN
      if (mq.size() == 0 && rv && !r && infl.size() > 0 && infl[0].ep == ep) begin
         exp_iv = 1'b1;
         exp_i  = mem_word(infl[0].pc);
         exp_pc = infl[0].pc;
      end
`endif
      chk("imem_req_valid", 32'(bus.imem_req_valid), 32'(exp_req));
      chk("imem_addr", bus.imem_addr, m_pc);
      chk("instr_valid", 32'(bus.instr_valid), 32'(exp_iv));
      if (exp_iv) begin
         chk("instr", bus.instr, exp_i);
         chk("instr_pc", bus.instr_pc, exp_pc);
      end
      if (bus.instr_valid) valid_cnt++;
      if (bus.instr_valid && bus.instr_ready) seen_pc.push_back(bus.instr_pc);
      // memory side follows what the DUT actually did
      if (rv) void'(mem_q.pop_front());
      if (bus.imem_req_valid && bus.imem_req_ready) begin
         mem_q.push_back('{addr: bus.imem_addr, due: cyc + int'($urandom_range(lat_max, lat_min))});
         acc_cnt++;
         acc_addr.push_back(bus.imem_addr);
      end
      // reference model
      mq_was_empty = (mq.size() == 0);
      keep = 1'b0;
      if (rv && infl.size() > 0) begin
         h = infl.pop_front();
         keep = !r && (h.ep == ep);
      end
      if (!r && !mq_was_empty && bus.instr_ready) void'(mq.pop_front());
      byp = 1'b0;
`ifdef IFU_BYPASS_EN
      byp = mq_was_empty && bus.instr_ready;
`endif
      if (keep && !byp) mq.push_back('{w: mem_word(h.pc), pc: h.pc});
      if (exp_req && bus.imem_req_ready) begin
         infl.push_back('{pc: m_pc, ep: ep});
         m_pc = m_pc + 32'd4;
      end
      if (r) begin
         mq.delete();
         ep++;
         m_pc = {bus.redirect_pc[31:2], 2'b00};
      end
      @(posedge clk);
      #1;
      bus.imem_rvalid = 1'b0;
      cyc++;
   endtask

   // Assert reset asynchronously, check outputs at once, then release after two edges.
   task automatic do_reset();
      bus.imem_rvalid = 1'b0;
      bus.redirect    = 1'b0;
      reset = 1'b0;
      #1;
      chk("rst_req_valid", 32'(bus.imem_req_valid), 32'h0);
      chk("rst_instr_valid", 32'(bus.instr_valid), 32'h0);
      chk("rst_instr", bus.instr, 32'h0);
      chk("rst_instr_pc", bus.instr_pc, 32'h0);
      chk("rst_imem_addr", bus.imem_addr, RESET_PC);
      mem_q.delete();
      infl.delete();
      mq.delete();
      m_pc = RESET_PC;
      ep = 0;
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   initial begin
      int n;
      logic found;
      bus.redirect       = 1'b0;
      bus.redirect_pc    = 32'h0;
      bus.imem_req_ready = 1'b0;
      bus.imem_rvalid    = 1'b0;
      bus.imem_rdata     = 32'h0;
      bus.instr_ready    = 1'b0;
      #2;
      do_reset();

      // decoder stalled: credit limits issue to DEPTH requests
      bus.imem_req_ready = 1'b1;
      bus.instr_ready = 1'b0;
      lat_min = 1; lat_max = 1;
      acc_cnt = 0;
      repeat (10) cycle();
      chk("stall_accepts", 32'(acc_cnt), 32'd4);
      acc_addr.delete();
      bus.instr_ready = 1'b1;
      repeat (12) cycle();
      chk("resume_addr", (acc_addr.size() > 0) ? acc_addr[0] : 32'hDEAD_BEEF, 32'h0000_3010);

      // steady streaming without gaps
      repeat (10) cycle();
      valid_cnt = 0;
      repeat (10) cycle();
      chk("stream_no_gap", 32'(valid_cnt), 32'd10);

      // drain, then three requests in flight and a misaligned redirect
      bus.imem_req_ready = 1'b0;
      n = 0;
      while ((mem_q.size() > 0 || mq.size() > 0) && n < 50) begin cycle(); n++; end
      chk("drain_empty", 32'(mem_q.size() + mq.size()), 32'd0);
      lat_min = 8; lat_max = 8;
      bus.imem_req_ready = 1'b1;
      repeat (3) cycle();
      bus.imem_req_ready = 1'b0;
      chk("inflight_three", 32'(mem_q.size()), 32'd3);
      bus.redirect = 1'b1;
      bus.redirect_pc = 32'h0000_4001;
      cycle();
      bus.redirect = 1'b0;
      bus.imem_req_ready = 1'b1;
      lat_min = 1; lat_max = 1;
      seen_pc.delete();
      chk("redir_addr", bus.imem_addr, 32'h0000_4000);
      chk("redir_flush", 32'(bus.instr_valid), 32'h0);
      n = 0;
      while (seen_pc.size() == 0 && n < 40) begin cycle(); n++; end
      chk("redir_first_pc", (seen_pc.size() > 0) ? seen_pc[0] : 32'hFFFF_FFFF, 32'h0000_4000);

      // redirect coinciding with a response and a pop
      bus.instr_ready = 1'b0;
      repeat (2) cycle();
      bus.instr_ready = 1'b1;
      found = 1'b0;
      n = 0;
      while (!found && n < 20) begin
         if (mq.size() > 0 && mem_q.size() > 0 && mem_q[0].due <= cyc) found = 1'b1;
         else begin cycle(); n++; end
      end
      chk("coincide_found", 32'(found), 32'h1);
      bus.redirect = 1'b1;
      bus.redirect_pc = 32'h0000_5000;
      cycle();
      bus.redirect = 1'b0;
      chk("coincide_flush", 32'(bus.instr_valid), 32'h0);
      repeat (8) cycle();

      // address wrap at the top of the address space
      acc_addr.delete();
      bus.redirect = 1'b1;
      bus.redirect_pc = 32'hFFFF_FFF8;
      cycle();
      bus.redirect = 1'b0;
      n = 0;
      while (acc_addr.size() < 3 && n < 20) begin cycle(); n++; end
      chk("wrap_cnt", 32'(acc_addr.size() >= 3), 32'h1);
      if (acc_addr.size() >= 3) begin
         chk("wrap_a0", acc_addr[0], 32'hFFFF_FFF8);
         chk("wrap_a1", acc_addr[1], 32'hFFFF_FFFC);
         chk("wrap_a2", acc_addr[2], 32'h0000_0000);
      end

      // randomized traffic
      lat_min = 1; lat_max = 5;
      repeat (600) begin
         bus.imem_req_ready = ($urandom_range(0, 9) < 7);
         bus.instr_ready    = ($urandom_range(0, 9) < 6);
         bus.redirect       = ($urandom_range(0, 99) < 4);
         bus.redirect_pc    = $urandom();
         cycle();
      end
      bus.redirect = 1'b0;

      // reset in the middle of traffic
      bus.imem_req_ready = 1'b1;
      bus.instr_ready = 1'b0;
      lat_min = 3; lat_max = 3;
      repeat (6) cycle();
      chk("pre_reset_busy", 32'(bus.instr_valid), 32'h1);
      do_reset();
      chk("post_reset_addr", bus.imem_addr, RESET_PC);
      bus.instr_ready = 1'b1;
      lat_min = 1; lat_max = 1;
      repeat (15) cycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end
endmodule
